// File: rtl/binary_frame_gen_pkg.sv
// Shared video package for the binary frame generator: state encoding,
// default timing constants, coordinate width and the rectangle pixel test.
package binary_frame_gen_pkg;

    localparam int COORD_W = 12;
    localparam int TMR_W   = 16;
    localparam int ACC_W   = 24;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_H_BLANK  = 64;
    localparam int DEF_V_PRE    = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VPRE   = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_HBLANK = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y0;
        logic [COORD_W-1:0] y1;
        logic               invert;
    } frame_cfg_t;

    // Inclusive unsigned bounds: x0>x1 or y0>y1 is simply empty, and bounds
    // past the active area never match, so clipping falls out for free.
    function automatic logic pixel_bit(input frame_cfg_t cfg,
                                       input logic [COORD_W-1:0] col,
                                       input logic [COORD_W-1:0] row);
        return cfg.invert ^ ((col >= cfg.x0) && (col <= cfg.x1) &&
                             (row >= cfg.y0) && (row <= cfg.y1));
    endfunction

endpackage

// File: rtl/frame_timing_cnt.sv
// Column/row/blank counters for the frame generator; reports end-of-phase
// events to the FSM and exposes next-cycle col/row for the registered pixel.
module frame_timing_cnt
    import binary_frame_gen_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int H_BLANK  = DEF_H_BLANK,
    parameter int V_PRE    = DEF_V_PRE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  state_t             state,
    output logic [COORD_W-1:0] col_nxt,
    output logic [COORD_W-1:0] row_nxt,
    output logic               pre_end,
    output logic               line_end,
    output logic               blank_end,
    output logic               frame_end
);

    localparam logic [COORD_W-1:0] COL_LAST   = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] ROW_LAST   = COORD_W'(V_ACTIVE - 1);
    localparam logic [TMR_W-1:0]   PRE_LOAD   = TMR_W'(V_PRE - 1);
    localparam logic [TMR_W-1:0]   BLANK_LOAD = TMR_W'(H_BLANK - 1);

    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] row;
    logic [TMR_W-1:0]   tmr;
    logic [TMR_W-1:0]   tmr_nxt;
    logic               last_line;

    assign pre_end   = (state == ST_VPRE)   && (tmr == '0);
    assign line_end  = (state == ST_ACTIVE) && (col == COL_LAST);
    assign blank_end = (state == ST_HBLANK) && (tmr == '0);
    assign frame_end = blank_end && last_line;

    // tmr is a down-counter shared by the VPRE and HBLANK phases; it is
    // preloaded in the phase before so it is ready on entry.
    always_comb begin
        col_nxt = '0;
        row_nxt = row;
        tmr_nxt = tmr;
        case (state)
            ST_VPRE: begin
                row_nxt = '0;
                tmr_nxt = pre_end ? BLANK_LOAD : tmr - 1'b1;
            end
            ST_ACTIVE: begin
                tmr_nxt = BLANK_LOAD;
                if (line_end) begin
                    col_nxt = '0;
                    row_nxt = (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col_nxt = col + 1'b1;
                end
            end
            ST_HBLANK: begin
                if (!blank_end)
                    tmr_nxt = tmr - 1'b1;
            end
            default: begin
                row_nxt = '0;
                tmr_nxt = PRE_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            tmr       <= '0;
            last_line <= 1'b0;
        end else begin
            col <= col_nxt;
            row <= row_nxt;
            tmr <= tmr_nxt;
            if (state == ST_VPRE)
                last_line <= 1'b0;
            else if (line_end)
                last_line <= (row == ROW_LAST);
        end
    end

endmodule

// File: rtl/binary_frame_gen.sv
// Binary test-frame generator: emits a video-style frame with a (possibly
// inverted) foreground rectangle and counts the foreground pixels per frame.
//
// state     | meaning
// ----------+----------------------------------------------------
// ST_IDLE   | waiting for start
// ST_VPRE   | vsync high, before the first active line
// ST_ACTIVE | pixel output, hsync/clken high
// ST_HBLANK | idle cycles after each line
// ST_DONE   | one cycle, frame_done pulse, bit_count updated
module binary_frame_gen
    import binary_frame_gen_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int H_BLANK  = DEF_H_BLANK,
    parameter int V_PRE    = DEF_V_PRE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               cont,
    input  logic [COORD_W-1:0] rect_x0,
    input  logic [COORD_W-1:0] rect_x1,
    input  logic [COORD_W-1:0] rect_y0,
    input  logic [COORD_W-1:0] rect_y1,
    input  logic               invert,
    output logic               post_frame_vsync,
    output logic               post_frame_hsync,
    output logic               post_frame_clken,
    output logic               post_img_bit,
    output logic               busy,
    output logic               frame_done,
    output logic [ACC_W-1:0]   bit_count
);

    state_t             state;
    frame_cfg_t         cfg;
    frame_cfg_t         cfg_in;
    logic [ACC_W-1:0]   acc;
    logic [COORD_W-1:0] col_nxt;
    logic [COORD_W-1:0] row_nxt;
    logic               pre_end;
    logic               line_end;
    logic               blank_end;
    logic               frame_end;

    assign cfg_in = {rect_x0, rect_x1, rect_y0, rect_y1, invert};

    frame_timing_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .H_BLANK  (H_BLANK),
        .V_PRE    (V_PRE)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .state     (state),
        .col_nxt   (col_nxt),
        .row_nxt   (row_nxt),
        .pre_end   (pre_end),
        .line_end  (line_end),
        .blank_end (blank_end),
        .frame_end (frame_end)
    );

    // Outputs are set on the transition into a state so they line up with
    // the state register; the pixel uses next-cycle col/row for that reason.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            cfg              <= '0;
            acc              <= '0;
            bit_count        <= '0;
            post_frame_vsync <= 1'b0;
            post_frame_hsync <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_bit     <= 1'b0;
            busy             <= 1'b0;
            frame_done       <= 1'b0;
        end else begin
            if (post_frame_clken && post_img_bit)
                acc <= acc + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state            <= ST_VPRE;
                        cfg              <= cfg_in;
                        acc              <= '0;
                        post_frame_vsync <= 1'b1;
                        busy             <= 1'b1;
                    end
                end
                ST_VPRE: begin
                    if (pre_end) begin
                        state            <= ST_ACTIVE;
                        post_frame_hsync <= 1'b1;
                        post_frame_clken <= 1'b1;
                        post_img_bit     <= pixel_bit(cfg, col_nxt, row_nxt);
                    end
                end
                ST_ACTIVE: begin
                    if (line_end) begin
                        state            <= ST_HBLANK;
                        post_frame_hsync <= 1'b0;
                        post_frame_clken <= 1'b0;
                        post_img_bit     <= 1'b0;
                    end else begin
                        post_img_bit     <= pixel_bit(cfg, col_nxt, row_nxt);
                    end
                end
                ST_HBLANK: begin
                    if (frame_end) begin
                        state            <= ST_DONE;
                        post_frame_vsync <= 1'b0;
                        frame_done       <= 1'b1;
                        bit_count        <= acc;
                    end else if (blank_end) begin
                        state            <= ST_ACTIVE;
                        post_frame_hsync <= 1'b1;
                        post_frame_clken <= 1'b1;
                        post_img_bit     <= pixel_bit(cfg, col_nxt, row_nxt);
                    end
                end
                ST_DONE: begin
                    frame_done <= 1'b0;
                    // start is not looked at here: start+cont gives one frame
                    if (cont) begin
                        state            <= ST_VPRE;
                        cfg              <= cfg_in;
                        acc              <= '0;
                        post_frame_vsync <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_binary_frame_gen.sv
// Directed bench for binary_frame_gen using a reduced frame geometry.
module tb_binary_frame_gen;

    localparam int HA = 12;
    localparam int VA = 6;
    localparam int HB = 3;
    localparam int VP = 4;
    localparam int FRAME_LEN = VP + VA * (HA + HB) + 1;
    localparam int BOUND = 4 * FRAME_LEN;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic        invert = 1'b0;
    logic [11:0] rect_x0 = '0;
    logic [11:0] rect_x1 = '0;
    logic [11:0] rect_y0 = '0;
    logic [11:0] rect_y1 = '0;
    logic        vsync, hsync, clken, img_bit, busy, frame_done;
    logic [23:0] bit_count;

    always #5 clk = ~clk;

    binary_frame_gen #(
        .H_ACTIVE (HA),
        .V_ACTIVE (VA),
        .H_BLANK  (HB),
        .V_PRE    (VP)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .cont             (cont),
        .rect_x0          (rect_x0),
        .rect_x1          (rect_x1),
        .rect_y0          (rect_y0),
        .rect_y1          (rect_y1),
        .invert           (invert),
        .post_frame_vsync (vsync),
        .post_frame_hsync (hsync),
        .post_frame_clken (clken),
        .post_img_bit     (img_bit),
        .busy             (busy),
        .frame_done       (frame_done),
        .bit_count        (bit_count)
    );

    typedef struct {
        logic [11:0] x0;
        logic [11:0] x1;
        logic [11:0] y0;
        logic [11:0] y1;
        logic        inv;
        int          exp_fg;
    } vec_t;

    int checks = 0;
    int failures = 0;

    vec_t cur_cfg, nxt_cfg;

    // monitor state
    int cur_len, cur_vs, cur_vlow, cur_fg, cur_hp, cur_badpix, cur_badh;
    int last_len, last_vs, last_vlow, last_fg, last_hp, last_badpix, last_badh;
    int pix_idx, hrun, hgap, done_cnt, bad_lvl;
    bit prev_h, in_line;

    function automatic logic model_bit(input vec_t c, input int col, input int row);
        return c.inv ^ ((col >= int'(c.x0)) && (col <= int'(c.x1)) &&
                        (row >= int'(c.y0)) && (row <= int'(c.y1)));
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        done_cnt = 0;
        bad_lvl  = 0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            cur_len = 0; cur_vs = 0; cur_vlow = 0; cur_fg = 0; cur_hp = 0;
            cur_badpix = 0; cur_badh = 0; pix_idx = 0; hrun = 0; hgap = 0;
            prev_h = 1'b0; in_line = 1'b0;
        end else begin
            if (busy) cur_len++;
            if (vsync) cur_vs++;
            if (busy && !vsync) cur_vlow++;
            if (hsync !== clken) bad_lvl++;
            if (!clken && img_bit) bad_lvl++;
            if (clken) begin
                if (img_bit !== model_bit(cur_cfg, pix_idx % HA, pix_idx / HA)) cur_badpix++;
                if (img_bit) cur_fg++;
                pix_idx++;
            end
            if (hsync) begin
                if (!prev_h) begin
                    if (in_line && hgap != HB) cur_badh++;
                    cur_hp++;
                    hrun = 0;
                end
                hrun++;
                in_line = 1'b1;
                hgap = 0;
            end else begin
                if (prev_h && hrun != HA) cur_badh++;
                if (in_line && vsync) hgap++;
            end
            prev_h = hsync;
            if (frame_done) begin
                if (hgap != HB) cur_badh++;
                last_len = cur_len; last_vs = cur_vs; last_vlow = cur_vlow;
                last_fg = cur_fg; last_hp = cur_hp; last_badpix = cur_badpix;
                last_badh = cur_badh;
                done_cnt++;
                cur_len = 0; cur_vs = 0; cur_vlow = 0; cur_fg = 0; cur_hp = 0;
                cur_badpix = 0; cur_badh = 0; pix_idx = 0; hgap = 0;
                in_line = 1'b0;
                cur_cfg = nxt_cfg;
            end
        end
    end

    task automatic drive_cfg(input vec_t v);
        rect_x0 = v.x0; rect_x1 = v.x1; rect_y0 = v.y0; rect_y1 = v.y1;
        invert = v.inv;
    endtask

    task automatic set_cfg(input vec_t v);
        drive_cfg(v);
        cur_cfg = v;
        nxt_cfg = v;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < BOUND) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({name, "_timeout"}, (done_cnt >= target) ? 1 : 0, 1);
    endtask

    task automatic check_frame(input string name, input int exp_fg);
        chk({name, "_len"}, last_len, FRAME_LEN);
        chk({name, "_vsync_hi"}, last_vs, FRAME_LEN - 1);
        chk({name, "_vsync_lo"}, last_vlow, 1);
        chk({name, "_hsync_pulses"}, last_hp, VA);
        chk({name, "_hsync_shape"}, last_badh, 0);
        chk({name, "_pixels"}, last_badpix, 0);
        chk({name, "_fg"}, last_fg, exp_fg);
        chk({name, "_bit_count"}, bit_count, exp_fg);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_vsync"}, vsync, 0);
        chk({name, "_hsync"}, hsync, 0);
        chk({name, "_clken"}, clken, 0);
        chk({name, "_bit"}, img_bit, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, frame_done, 0);
        chk({name, "_bit_count"}, bit_count, 0);
    endtask

    vec_t vecs[9];
    vec_t vb;

    initial begin
        int base, n;
        vecs[0] = '{12'd2,    12'd5,    12'd1, 12'd3,    1'b0, 12};
        vecs[1] = '{12'd2,    12'd5,    12'd1, 12'd3,    1'b1, 60};
        vecs[2] = '{12'd7,    12'd6,    12'd0, 12'd5,    1'b0, 0};
        vecs[3] = '{12'd7,    12'd6,    12'd0, 12'd5,    1'b1, 72};
        vecs[4] = '{12'd0,    12'd4095, 12'd0, 12'd4095, 1'b0, 72};
        vecs[5] = '{12'd10,   12'd100,  12'd5, 12'd5,    1'b0, 2};
        vecs[6] = '{12'd0,    12'd0,    12'd0, 12'd0,    1'b0, 1};
        vecs[7] = '{12'd0,    12'd11,   12'd4, 12'd2,    1'b0, 0};
        vecs[8] = '{12'd11,   12'd11,   12'd0, 12'd5,    1'b0, 6};
        vb      = '{12'd0,    12'd2,    12'd0, 12'd1,    1'b0, 6};
        set_cfg(vecs[0]);

        // reset state, and no frame without start
        #23;
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk("idle_after_reset_busy", busy, 0);
        chk("idle_after_reset_vsync", vsync, 0);

        // table-driven single frames
        for (int i = 0; i < 9; i++) begin
            set_cfg(vecs[i]);
            base = done_cnt;
            pulse_start();
            wait_done(base + 1, $sformatf("vec%0d", i));
            check_frame($sformatf("vec%0d", i), vecs[i].exp_fg);
            repeat (3) @(posedge clk);
            #1 chk($sformatf("vec%0d_idle", i), busy, 0);
        end

        // start during ACTIVE is ignored
        set_cfg(vecs[0]);
        base = done_cnt;
        pulse_start();
        n = 0;
        while (!clken && n < BOUND) begin @(negedge clk); n++; end
        chk("busy_start_reach_active", clken, 1);
        pulse_start();
        wait_done(base + 1, "busy_start");
        check_frame("busy_start", 12);
        repeat (20) @(posedge clk);
        #1 chk("busy_start_frames", done_cnt - base, 1);
        chk("busy_start_idle", busy, 0);

        // back-to-back with mid-frame rect change, start+cont in DONE
        set_cfg(vecs[0]);
        cont = 1'b1;
        base = done_cnt;
        pulse_start();
        repeat (30) @(posedge clk);
        #1 drive_cfg(vb);
        nxt_cfg = vb;
        n = 0;
        @(negedge clk);
        while (!frame_done && n < BOUND) begin @(negedge clk); n++; end
        chk("b2b_first_done", frame_done, 1);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cont = 1'b0;
        chk("b2b_vsync_back", vsync, 1);
        check_frame("b2b_f1", 12);
        wait_done(base + 2, "b2b_f2");
        check_frame("b2b_f2", 6);
        repeat (20) @(posedge clk);
        #1 chk("b2b_frames", done_cnt - base, 2);
        chk("b2b_idle", busy, 0);

        // reset at row 3 of a frame
        set_cfg(vecs[1]);
        pulse_start();
        n = 0;
        while (pix_idx < 3 * HA && n < BOUND) begin @(posedge clk); n++; end
        chk("rst_reach_row3", (pix_idx >= 3 * HA) ? 1 : 0, 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        #1 chk("rst_start_ignored", busy, 0);
        #3 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("rst_release_idle", busy, 0);
        set_cfg(vecs[1]);
        base = done_cnt;
        pulse_start();
        wait_done(base + 1, "rst_after");
        check_frame("rst_after", 60);

        chk("level_consistency", bad_lvl, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
